// File: rtl/fp16_pkg.sv
// Shared binary16 field widths, canonical encodings and the divider FSM state type.
package fp16_pkg;
  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int MANT_W = FRAC_W + 1;
  localparam int BIAS   = 15;
  localparam int EXP_SW = 7;
  localparam int Q_W    = 13;
  localparam int ITERS  = 13;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] PINF = 16'h7C00;
  localparam logic [15:0] NINF = 16'hFC00;

  typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_t;
endpackage

// File: rtl/fp16_classify.sv
// Combinational operand classifier: zero/inf/NaN detection and the implicit-1 mantissa.
module fp16_classify
  import fp16_pkg::*;
#(
  parameter int FLUSH_SUBNORM = 1
) (
  input  logic [EXP_W+FRAC_W-1:0] mag,
  output logic                    is_zero,
  output logic                    is_inf,
  output logic                    is_nan,
  output logic [MANT_W-1:0]       mant
);
  logic exp_zero, exp_ones, frac_zero;

  assign exp_zero  = (mag[EXP_W+FRAC_W-1:FRAC_W] == '0);
  assign exp_ones  = (mag[EXP_W+FRAC_W-1:FRAC_W] == '1);
  assign frac_zero = (mag[FRAC_W-1:0] == '0);

  // Subnormals collapse onto zero, so they never reach the mantissa divider.
  assign is_zero = exp_zero & (frac_zero | (FLUSH_SUBNORM != 0));
  assign is_inf  = exp_ones & frac_zero;
  assign is_nan  = exp_ones & ~frac_zero;
  assign mant    = {~exp_zero, mag[FRAC_W-1:0]};
endmodule

// File: rtl/fp16_div.sv
// Multi-cycle binary16 divider: restoring mantissa division, round-to-nearest-even,
// fixed 15-cycle latency for every operand pair including special values.
module fp16_div
  import fp16_pkg::*;
#(
  parameter int FLUSH_SUBNORM = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        dz,
  output logic        inv
);
  state_t            state_q, state_d;
  logic              rdy_q;
  logic [3:0]        cnt_q;
  logic [15:0]       a_q, b_q, x_q, x_d;
  logic              dz_q, dz_d, inv_q, inv_d;
  logic [Q_W-1:0]    rem_q, quo_q, div_trial, rem_nxt;
  logic              q_bit;

  logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [MANT_W-1:0] mant_a, mant_b;

  fp16_classify #(.FLUSH_SUBNORM(FLUSH_SUBNORM)) u_cls_a (
    .mag(a_q[14:0]), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan), .mant(mant_a));
  fp16_classify #(.FLUSH_SUBNORM(FLUSH_SUBNORM)) u_cls_b (
    .mag(b_q[14:0]), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan), .mant(mant_b));

  // One restoring step: subtract the divisor when it fits, record the quotient bit.
  assign div_trial = rem_q - {{(Q_W-MANT_W){1'b0}}, mant_b};
  assign q_bit     = (rem_q >= {{(Q_W-MANT_W){1'b0}}, mant_b});
  assign rem_nxt   = q_bit ? div_trial : rem_q;

  logic                     hi, guard, sticky, round_up, sign;
  logic [MANT_W-1:0]        mant_t;
  logic [MANT_W:0]          mant_sum;
  logic signed [EXP_SW-1:0] exp_t;
  logic [15:0]              inf_s, zero_s;

  always_comb begin
    hi       = quo_q[Q_W-1];
    mant_t   = hi ? quo_q[12:2] : quo_q[11:1];
    guard    = hi ? quo_q[1] : quo_q[0];
    sticky   = (hi & quo_q[0]) | (rem_q != '0);
    round_up = guard & (sticky | mant_t[0]);
    mant_sum = {1'b0, mant_t} + {{MANT_W{1'b0}}, round_up};
    exp_t    = $signed({2'b00, a_q[14:10]}) - $signed({2'b00, b_q[14:10]})
             + $signed(EXP_SW'(hi ? BIAS : BIAS - 1))
             + $signed({{(EXP_SW-1){1'b0}}, mant_sum[MANT_W]});
    sign     = a_q[15] ^ b_q[15];
    inf_s    = sign ? NINF : PINF;
    zero_s   = {sign, 15'b0};
    dz_d     = 1'b0;
    inv_d    = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      x_d   = QNAN;
      inv_d = 1'b1;
    end else if (a_inf) begin
      x_d = inf_s;
    end else if (b_inf) begin
      x_d = zero_s;
    end else if (b_zero) begin
      x_d  = inf_s;
      dz_d = 1'b1;
    end else if (a_zero) begin
      x_d = zero_s;
    end else if (exp_t >= 7'sd31) begin
      x_d = inf_s;
    end else if (exp_t <= 7'sd0) begin
      x_d = zero_s;
    end else begin
      // On mantissa carry-out the low bits are already zero, matching 1.0 at exp+1.
      x_d = {sign, exp_t[EXP_W-1:0], mant_sum[FRAC_W-1:0]};
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = rdy_q;
        if (in_valid && rdy_q) state_d = DIV;
      end
      DIV:  if (cnt_q == 4'(ITERS)) state_d = RND;
      RND:  state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      x_q     <= '0;
      dz_q    <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      case (state_q)
        IDLE: if (in_valid && rdy_q) begin
          a_q   <= a;
          b_q   <= b;
          cnt_q <= '0;
        end
        DIV: begin
          cnt_q <= cnt_q + 4'd1;
          // First DIV cycle seeds the remainder; the following 13 produce quotient bits.
          if (cnt_q == '0) begin
            rem_q <= {{(Q_W-MANT_W){1'b0}}, mant_a};
            quo_q <= '0;
          end else begin
            rem_q <= {rem_nxt[Q_W-2:0], 1'b0};
            quo_q <= {quo_q[Q_W-2:0], q_bit};
          end
        end
        RND: begin
          x_q   <= x_d;
          dz_q  <= dz_d;
          inv_q <= inv_d;
        end
        default: ;
      endcase
    end
  end

  assign x   = x_q;
  assign dz  = dz_q;
  assign inv = inv_q;
endmodule
